// File: rtl/ysyx_23060208_lsu_axi_master.sv
// Load/store AXI4-Lite initiator: one pipeline request at a time, one response each.
// Optional misalignment trap: define YSYX_23060208_LSU_MISALIGN_CHECK_EN.
module ysyx_23060208_lsu_axi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,

  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_done, w_done;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [1:0]            byte_off;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] rshift;
  logic [DATA_WIDTH-1:0] load_data;
  logic [3:0]            strb_base;
  logic                  misaligned;

`ifdef YSYX_23060208_LSU_MISALIGN_CHECK_EN
  // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign byte_off = addr_q[1:0];
  assign shamt    = {byte_off, 3'b000};
  assign rshift   = m_rdata >> shamt;

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{rshift[7]}},  rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_data = {24'h0, rshift[7:0]};
      3'b101:  load_data = {16'h0, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  // Misaligned stores without the trap simply lose the lanes shifted past bit 31.
  assign m_wdata    = wdata_q << shamt;
  assign m_wstrb    = strb_base << byte_off;
  assign m_awaddr   = addr_q;
  assign m_araddr   = addr_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)   state_next = RESP;
          else if (req_wen) state_next = AW_W;
          else              state_next = AR;
        end
      end
      AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_next = R;
      end
      R: begin
        m_rready = 1'b1;
        if (m_rvalid) state_next = RESP;
      end
      AW_W: begin
        // Valids come only from state and done flags, never from the readies.
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        if ((aw_done || m_awready) && (w_done || m_wready)) state_next = B;
      end
      B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so bus addresses and response data start at a known 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q   <= req_addr;
          funct3_q <= req_funct3;
          wdata_q  <= req_wdata;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          if (misaligned) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        R: if (m_rvalid) begin
          rdata_q <= load_data;
          err_q   <= (m_rresp != 2'b00);
        end
        AW_W: begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
        B: if (m_bvalid) begin
          rdata_q <= '0;
          err_q   <= (m_bresp != 2'b00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_lsu_axi_master.sv
// Directed bench for the LSU AXI master; responses are checked by a scoreboard monitor.
module tb_ysyx_23060208_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_23060208_lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got rdata %h err %b, expected no response", resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.data);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 1;
    m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
  endtask

  // Zero-wait load: accept at cycle 0, arvalid at 1, rvalid at 2, resp_valid at 3.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rd,
                         input logic [1:0] rr, input logic [31:0] exp_d, input logic exp_e);
    check("ld_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_wen = 0; req_funct3 = f3; req_addr = addr; req_wdata = 32'h5a5a_5a5a;
    m_arready = 1; resp_ready = 1;
    exp_q.push_back('{err: exp_e, data: exp_d});
    tick();
    req_valid = 0;
    check("ld_arvalid", {31'b0, m_arvalid}, 32'd1);
    check("ld_araddr", m_araddr, addr);
    tick();
    m_arready = 0;
    check("ld_rready", {31'b0, m_rready}, 32'd1);
    m_rvalid = 1; m_rdata = rd; m_rresp = rr;
    tick();
    m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    check("ld_resp_latency", {31'b0, resp_valid}, 32'd1);
    tick();
    check("ld_resp_done", {31'b0, resp_valid}, 32'd0);
  endtask

  // Zero-wait store: both address and data handshake in cycle 1, B in cycle 2.
  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_wd, input logic [3:0] exp_strb,
                          input logic [1:0] br);
    check("st_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_wen = 1; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    m_awready = 1; m_wready = 1; resp_ready = 1;
    exp_q.push_back('{err: (br != 2'b00), data: 32'h0});
    tick();
    req_valid = 0;
    check("st_awvalid", {31'b0, m_awvalid}, 32'd1);
    check("st_wvalid", {31'b0, m_wvalid}, 32'd1);
    check("st_awaddr", m_awaddr, addr);
    check("st_wdata", m_wdata, exp_wd);
    check("st_wstrb", {28'b0, m_wstrb}, {28'b0, exp_strb});
    tick();
    m_awready = 0; m_wready = 0;
    check("st_aw_dropped", {31'b0, m_awvalid}, 32'd0);
    check("st_bready", {31'b0, m_bready}, 32'd1);
    m_bvalid = 1; m_bresp = br;
    tick();
    m_bvalid = 0; m_bresp = 0;
    check("st_resp_valid", {31'b0, resp_valid}, 32'd1);
    tick();
    check("st_resp_done", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valids", {26'b0, m_arvalid, m_awvalid, m_wvalid, resp_valid, m_bready, m_rready}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    rst = 0;
    tick();

    // Loads: alignment shift and extension.
    do_load(32'h8000_0003, 3'b000, 32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 1'b0);
    do_load(32'h8000_0001, 3'b100, 32'h8765_4321, 2'b00, 32'h0000_0043, 1'b0);
    do_load(32'h8000_0002, 3'b001, 32'h8765_4321, 2'b00, 32'hFFFF_8765, 1'b0);
    do_load(32'h8000_0002, 3'b101, 32'h8765_4321, 2'b00, 32'h0000_8765, 1'b0);
    do_load(32'h8000_0004, 3'b010, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0);
    do_load(32'h8000_0000, 3'b011, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0);
    do_load(32'h8000_0000, 3'b000, 32'h0000_007F, 2'b00, 32'h0000_007F, 1'b0);

    // Stores: lane shift, strobes, bresp error.
    do_store(32'h8000_0002, 3'b001, 32'h0000_ABCD, 32'hABCD_0000, 4'b1100, 2'b00);
    do_store(32'h8000_0001, 3'b000, 32'h0000_00EE, 32'h0000_EE00, 4'b0010, 2'b00);
    do_store(32'h8000_0008, 3'b010, 32'h1234_5678, 32'h1234_5678, 4'b1111, 2'b10);

    // Store where the address handshake comes 3 cycles after the data handshake.
    req_valid = 1; req_wen = 1; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
    req_wdata = 32'h1234_5678; m_wready = 1; m_awready = 0; resp_ready = 1;
    exp_q.push_back('{err: 1'b0, data: 32'h0});
    tick();
    req_valid = 0;
    check("late_aw_awvalid_c1", {31'b0, m_awvalid}, 32'd1);
    check("late_aw_wvalid_c1", {31'b0, m_wvalid}, 32'd1);
    tick();
    m_wready = 0;
    check("late_aw_wvalid_dropped", {31'b0, m_wvalid}, 32'd0);
    check("late_aw_awvalid_c2", {31'b0, m_awvalid}, 32'd1);
    tick();
    check("late_aw_awvalid_c3", {31'b0, m_awvalid}, 32'd1);
    check("late_aw_no_bready", {31'b0, m_bready}, 32'd0);
    tick();
    check("late_aw_awvalid_c4", {31'b0, m_awvalid}, 32'd1);
    m_awready = 1;
    tick();
    m_awready = 0;
    check("late_aw_awvalid_dropped", {31'b0, m_awvalid}, 32'd0);
    check("late_aw_bready_c5", {31'b0, m_bready}, 32'd1);
    tick();
    check("late_aw_bready_c6", {31'b0, m_bready}, 32'd1);
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    check("late_aw_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("late_aw_bready_off", {31'b0, m_bready}, 32'd0);
    tick();
    check("late_aw_idle", {31'b0, req_ready}, 32'd1);
    check("late_aw_one_resp", {31'b0, resp_valid}, 32'd0);

    // Load with slave error, late rvalid and stalled response.
    req_valid = 1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
    m_arready = 1; resp_ready = 0;
    exp_q.push_back('{err: 1'b1, data: 32'hDEAD_BEEF});
    tick();
    req_valid = 0;
    check("stall_arvalid", {31'b0, m_arvalid}, 32'd1);
    tick();
    m_arready = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rready_wait", {31'b0, m_rready}, 32'd1);
      check("stall_no_resp", {31'b0, resp_valid}, 32'd0);
      tick();
    end
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
    tick();
    m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    for (int i = 0; i < 4; i++) begin
      check("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("stall_resp_err", {31'b0, resp_err}, 32'd1);
      tick();
    end
    resp_ready = 1;
    tick();
    check("stall_resp_done", {31'b0, resp_valid}, 32'd0);

    // Reset while waiting in R: no response may follow.
    req_valid = 1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0030; m_arready = 1;
    tick();
    req_valid = 0;
    check("rstmid_arvalid", {31'b0, m_arvalid}, 32'd1);
    tick();
    m_arready = 0;
    check("rstmid_in_r", {31'b0, m_rready}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("rstmid_valids", {26'b0, m_arvalid, m_awvalid, m_wvalid, resp_valid, m_bready, m_rready}, 32'd0);
    check("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    m_rvalid = 1; m_rdata = 32'h1111_1111;
    tick();
    m_rvalid = 0;
    check("rstmid_stale_r_ignored", {31'b0, resp_valid}, 32'd0);
    tick();
    check("rstmid_still_idle", {31'b0, req_ready}, 32'd1);

`ifdef YSYX_23060208_LSU_MISALIGN_CHECK_EN
    // Misaligned word load: no bus traffic, error response the cycle after accept.
    req_valid = 1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0001;
    m_arready = 1; resp_ready = 1;
    exp_q.push_back('{err: 1'b1, data: 32'h0});
    tick();
    req_valid = 0;
    check("mis_lw_no_arvalid", {31'b0, m_arvalid}, 32'd0);
    check("mis_lw_resp_valid", {31'b0, resp_valid}, 32'd1);
    tick();
    m_arready = 0;
    check("mis_lw_no_arvalid_after", {31'b0, m_arvalid}, 32'd0);
    check("mis_lw_idle", {31'b0, req_ready}, 32'd1);
    // Misaligned halfword store: no AW/W.
    req_valid = 1; req_wen = 1; req_funct3 = 3'b001; req_addr = 32'h8000_0003;
    req_wdata = 32'h0000_ABCD;
    exp_q.push_back('{err: 1'b1, data: 32'h0});
    tick();
    req_valid = 0;
    check("mis_sh_no_aw_w", {30'b0, m_awvalid, m_wvalid}, 32'd0);
    check("mis_sh_resp_valid", {31'b0, resp_valid}, 32'd1);
    tick();
`else
    // Without the trap, misaligned accesses go to the bus and truncate at the word edge.
    do_load(32'h8000_0001, 3'b010, 32'h1122_3344, 2'b00, 32'h0011_2233, 1'b0);
    do_store(32'h8000_0003, 3'b001, 32'h0000_ABCD, 32'hCD00_0000, 4'b1000, 2'b00);
`endif

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
